// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if / processor_help : shared fetch types and the fetch-stage bus
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package processor_help;
   localparam int SUPER_SCALAR_WIDTH = 2;

   typedef logic [31:0] Word;

   typedef struct packed {
      Word instruction;
      Word program_counter;
   } FetchResult;
endpackage

interface fetch_if;
   import processor_help::*;

   logic                                 imem_req_valid_out;
   logic                                 imem_req_ready_in;
   Word                                  imem_req_addr_out;
   logic                                 imem_resp_valid_in;
   Word        [SUPER_SCALAR_WIDTH-1:0]  imem_resp_data_in;
   logic                                 redirect_valid_in;
   Word                                  redirect_pc_in;
   logic                                 decode_ready_in;
   logic                                 decode_valid_out;
   FetchResult [SUPER_SCALAR_WIDTH-1:0]  decode_payload_out;

   modport master (
      output imem_req_valid_out,
      output imem_req_addr_out,
      output decode_valid_out,
      output decode_payload_out,
      input  imem_req_ready_in,
      input  imem_resp_valid_in,
      input  imem_resp_data_in,
      input  redirect_valid_in,
      input  redirect_pc_in,
      input  decode_ready_in
   );

   modport slave (
      input  imem_req_valid_out,
      input  imem_req_addr_out,
      input  decode_valid_out,
      input  decode_payload_out,
      output imem_req_ready_in,
      output imem_resp_valid_in,
      output imem_resp_data_in,
      output redirect_valid_in,
      output redirect_pc_in,
      output decode_ready_in
   );
endinterface

`default_nettype wire

// File: rtl/fetch.sv
// ----------------------------------------------------------------------------
// fetch : PC, credit-limited imem requests, response FIFO, decode handshake.
// Optional: FETCH_PERF_COUNTERS_EN (perf ports), FETCH_ASSERT_EN (checks).
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch
   import processor_help::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  wire logic   clk_in,
   input  wire logic   rst_n_in,
   fetch_if.master     bus
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_bundles_out,
   output logic [31:0] perf_stall_cycles_out
`endif
);

   localparam int          c_PTR_W        = $clog2(DEPTH);
   localparam int          c_CNT_W        = $clog2(DEPTH + 1);
   localparam logic [31:0] c_BUNDLE_BYTES = 32'(4 * SUPER_SCALAR_WIDTH);
   localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

   Word                                 r_fetch_pc;
   FetchResult [SUPER_SCALAR_WIDTH-1:0] r_fifo [DEPTH];
   logic [c_PTR_W-1:0]                  r_fifo_rd;
   logic [c_PTR_W-1:0]                  r_fifo_wr;
   logic [c_CNT_W-1:0]                  r_fifo_count;
   Word                                 r_addr_q [DEPTH];
   logic [c_PTR_W-1:0]                  r_aq_rd;
   logic [c_PTR_W-1:0]                  r_aq_wr;
   logic [c_CNT_W-1:0]                  r_outstanding;
   logic [c_CNT_W-1:0]                  r_drop_count;

   logic                                w_credit_ok;
   logic                                w_req_fire;
   logic                                w_resp;
   logic                                w_push;
   logic                                w_pop;
   FetchResult [SUPER_SCALAR_WIDTH-1:0] w_bundle;

   // Every accepted request owns a FIFO slot until its bundle is consumed.
   assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < c_DEPTH_EXT;

   assign bus.imem_req_valid_out = rst_n_in && !bus.redirect_valid_in && w_credit_ok;
   assign bus.imem_req_addr_out  = r_fetch_pc;
   assign bus.decode_valid_out   = (r_fifo_count != '0) && !bus.redirect_valid_in;
   assign bus.decode_payload_out = r_fifo[r_fifo_rd];

   assign w_req_fire = bus.imem_req_valid_out && bus.imem_req_ready_in;
   assign w_resp     = bus.imem_resp_valid_in && (r_outstanding != '0);
   assign w_push     = w_resp && (r_drop_count == '0) && !bus.redirect_valid_in;
   assign w_pop      = bus.decode_valid_out && bus.decode_ready_in;

   always_comb begin
      w_bundle = '0;
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
         w_bundle[i].instruction     = bus.imem_resp_data_in[i];
         w_bundle[i].program_counter = r_addr_q[r_aq_rd] + 32'(4 * i);
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_fifo[r_fifo_wr] <= w_bundle;
      end
      if (w_req_fire) begin
         r_addr_q[r_aq_wr] <= r_fetch_pc;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_fetch_pc    <= RESET_PC;
         r_fifo_rd     <= '0;
         r_fifo_wr     <= '0;
         r_fifo_count  <= '0;
         r_aq_rd       <= '0;
         r_aq_wr       <= '0;
         r_outstanding <= '0;
         r_drop_count  <= '0;
      end else begin
         r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_resp);
         if (w_req_fire) begin
            r_aq_wr <= r_aq_wr + c_PTR_W'(1);
         end
         if (w_resp) begin
            r_aq_rd <= r_aq_rd + c_PTR_W'(1);
         end

         if (bus.redirect_valid_in) begin
            r_fetch_pc   <= bus.redirect_pc_in;
            // Every request still in flight is wrong-path; earlier drops are a subset of these.
            r_drop_count <= r_outstanding - c_CNT_W'(w_resp);
            r_fifo_rd    <= r_fifo_wr;
            r_fifo_count <= '0;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + c_BUNDLE_BYTES;
            end
            if (w_resp && (r_drop_count != '0)) begin
               r_drop_count <= r_drop_count - c_CNT_W'(1);
            end
            if (w_push) begin
               r_fifo_wr <= r_fifo_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_fifo_rd <= r_fifo_rd + c_PTR_W'(1);
            end
            r_fifo_count <= r_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
         end
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         perf_bundles_out      <= '0;
         perf_stall_cycles_out <= '0;
      end else begin
         if (w_pop && (perf_bundles_out != 32'hFFFF_FFFF)) begin
            perf_bundles_out <= perf_bundles_out + 32'd1;
         end
         if (bus.decode_valid_out && !bus.decode_ready_in &&
             (perf_stall_cycles_out != 32'hFFFF_FFFF)) begin
            perf_stall_cycles_out <= perf_stall_cycles_out + 32'd1;
         end
      end
   end
`endif

`ifdef FETCH_ASSERT_EN
   always_ff @(posedge clk_in) begin
      if (rst_n_in) begin
         assert (!(bus.imem_resp_valid_in && (r_outstanding == '0)))
            else $error("fetch: imem response with no request outstanding");
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ----------------------------------------------------------------------------
// tb_fetch : directed self-checking bench for fetch (DEPTH=4, W=2, L=1 memory)
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch;
   import processor_help::*;

   logic clk;
   logic rst_n;
   logic mem_stall;
   int   tests;
   int   fails;
   Word  mq[$];

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perf_bundles;
   logic [31:0] perf_stalls;
`endif

   fetch_if bus ();

   fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (4)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .perf_bundles_out      (perf_bundles),
      .perf_stall_cycles_out (perf_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "tb_fetch watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: capture the request handshake, then model a latency-1 memory.
   task automatic tick();
      logic fire;
      Word  a;
      #1;
      fire = bus.imem_req_valid_out && bus.imem_req_ready_in;
      a    = bus.imem_req_addr_out;
      @(posedge clk);
      #1;
      if (fire) mq.push_back(a);
      if (!mem_stall && mq.size() != 0) begin
         a = mq.pop_front();
         bus.imem_resp_valid_in = 1'b1;
         for (int i = 0; i < SUPER_SCALAR_WIDTH; i++)
            bus.imem_resp_data_in[i] = (a + 32'(4 * i)) ^ 32'hDEAD_0000;
      end else begin
         bus.imem_resp_valid_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      bus.imem_resp_valid_in = 1'b0;
      bus.redirect_valid_in  = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      mem_stall = 1'b0;
      bus.imem_req_ready_in  = 1'b1;
      bus.imem_resp_valid_in = 1'b0;
      bus.imem_resp_data_in  = '0;
      bus.redirect_valid_in  = 1'b0;
      bus.redirect_pc_in     = '0;
      bus.decode_ready_in    = 1'b1;

      // Reset state and streaming with decode always ready
      repeat (2) tick();
      chk("rst_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
      chk("rst_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("c0_req_valid", 32'(bus.imem_req_valid_out), 32'd1);
      chk("c0_req_addr", bus.imem_req_addr_out, 32'h0000_0000);
      tick();
      chk("c1_req_addr", bus.imem_req_addr_out, 32'h0000_0008);
      chk("c1_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      tick();
      chk("c2_dec_valid", 32'(bus.decode_valid_out), 32'd1);
      chk("c2_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0000);
      chk("c2_pc1", bus.decode_payload_out[1].program_counter, 32'h0000_0004);
      chk("c2_ins1", bus.decode_payload_out[1].instruction, 32'hDEAD_0004);
      chk("c2_req_addr", bus.imem_req_addr_out, 32'h0000_0010);
      tick();
      chk("c3_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0008);
      chk("c3_ins0", bus.decode_payload_out[0].instruction, 32'hDEAD_0008);
      tick();
      chk("c4_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0010);

      // Decode stalls for 5 cycles: FIFO fills, requests stop, head stays put
      tick();
      bus.decode_ready_in = 1'b0;
      #1;
      chk("st5_valid", 32'(bus.decode_valid_out), 32'd1);
      chk("st5_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0018);
      tick();
      chk("st6_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0018);
      tick();
      chk("st7_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
      chk("st7_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0018);
      tick();
      chk("st8_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
      tick();
      chk("st9_valid", 32'(bus.decode_valid_out), 32'd1);
      chk("st9_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0018);
      tick();
      bus.decode_ready_in = 1'b1;
      #1;
      chk("dr10_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0018);
      tick();
      chk("dr11_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0020);
      tick();
      chk("dr12_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0028);
      tick();
      chk("dr13_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0030);
      tick();
      chk("dr14_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0038);
      tick();
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_bundles", perf_bundles, 32'd8);
      chk("perf_stalls", perf_stalls, 32'd5);
`endif

      // Redirect to 0x100 with two requests outstanding
      mem_stall = 1'b1;
      do_reset();
      tick();
      tick();
      bus.imem_req_ready_in = 1'b0;
      bus.redirect_valid_in = 1'b1;
      bus.redirect_pc_in    = 32'h0000_0100;
      #1;
      chk("rd2_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
      tick();
      bus.redirect_valid_in = 1'b0;
      bus.imem_req_ready_in = 1'b1;
      mem_stall = 1'b0;
      #1;
      chk("rd3_req_valid", 32'(bus.imem_req_valid_out), 32'd1);
      chk("rd3_req_addr", bus.imem_req_addr_out, 32'h0000_0100);
      tick();
      chk("rd4_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      tick();
      chk("rd5_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      tick();
      chk("rd6_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      tick();
      chk("rd7_dec_valid", 32'(bus.decode_valid_out), 32'd1);
      chk("rd7_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0100);
      chk("rd7_pc1", bus.decode_payload_out[1].program_counter, 32'h0000_0104);

      // Redirect with a response arriving and the credit exhausted; PC wrap
      bus.decode_ready_in = 1'b0;
      do_reset();
      repeat (4) tick();
      chk("rw4_credit_req", 32'(bus.imem_req_valid_out), 32'd0);
      chk("rw4_pre_valid", 32'(bus.decode_valid_out), 32'd1);
      bus.decode_ready_in   = 1'b1;
      bus.redirect_valid_in = 1'b1;
      bus.redirect_pc_in    = 32'hFFFF_FFF8;
      #1;
      chk("rw4_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      chk("rw4_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
      tick();
      bus.redirect_valid_in = 1'b0;
      #1;
      chk("rw5_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      chk("rw5_req_addr", bus.imem_req_addr_out, 32'hFFFF_FFF8);
      tick();
      chk("rw6_req_addr", bus.imem_req_addr_out, 32'h0000_0000);
      chk("rw6_dec_valid", 32'(bus.decode_valid_out), 32'd0);
      tick();
      chk("rw7_dec_valid", 32'(bus.decode_valid_out), 32'd1);
      chk("rw7_pc0", bus.decode_payload_out[0].program_counter, 32'hFFFF_FFF8);
      chk("rw7_pc1", bus.decode_payload_out[1].program_counter, 32'hFFFF_FFFC);
      tick();
      chk("rw8_pc0", bus.decode_payload_out[0].program_counter, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
